// File: rtl/rr_arbiter_4ch.sv
// rtl/rr_arbiter_4ch.sv - four-channel round-robin burst arbiter with registered byte output
//
// Arbitrates four valid/ready byte producers, drives the downstream 4:1 mux
// select and captures the selected byte into a registered output stage.
// A winning channel keeps the grant for up to MAX_BURST bytes.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid[3:0]     per-channel data valid
//   in_ready[3:0]     per-channel accept (at most one bit high)
//   data0..data3      per-channel bytes
//   sel               current grant index / downstream mux select
//   out_data          registered captured byte
//   out_valid         out_data holds an untaken byte
//   out_ready         consumer accepts out_data
//   busy              high while a grant is active
module rr_arbiter_4ch #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              load_ok;
    logic              xfer;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic [DATA_W-1:0] mux_byte;

    // The output register can accept a new byte when empty or being drained.
    assign load_ok = !out_valid_q || out_ready;
    assign xfer    = (state_q == GRANT) && in_valid[sel_q] && load_ok;

    always_comb begin
        case (sel_q)
            2'd0:    mux_byte = data0;
            2'd1:    mux_byte = data1;
            2'd2:    mux_byte = data2;
            default: mux_byte = data3;
        endcase
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr_q;
        idx    = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (in_valid[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state_q == GRANT) begin
            in_ready[sel_q] = load_ok;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!in_valid[sel_q]) begin
                    // Producer dropped its request: release the grant early.
                    state_d = IDLE;
                    ptr_d   = sel_q + 2'd1;
                end else if (xfer) begin
                    out_data_d  = mux_byte;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        ptr_d   = sel_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// tb/tb_rr_arbiter_4ch.sv - directed vector bench for rr_arbiter_4ch
module tb_rr_arbiter_4ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] data0, data1, data2, data3;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    logic [3:0] in_valid_b;
    logic [3:0] in_ready_b;
    logic [1:0] sel_b;
    logic [7:0] out_data_b;
    logic       out_valid_b;
    logic       busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter_4ch #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    rr_arbiter_4ch #(.DATA_W(8), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data0(8'h10), .data1(8'h11), .data2(8'h12), .data3(8'h13),
        .sel(sel_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(1'b1), .busy(busy_b)
    );

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic       busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input logic [1:0] e_sel, input logic [3:0] e_rdy,
                            input logic e_ov, input logic [7:0] e_od, input logic e_busy);
        chk({tag, ".sel"},       {6'd0, sel},       {6'd0, e_sel});
        chk({tag, ".in_ready"},  {4'd0, in_ready},  {4'd0, e_rdy});
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e_ov});
        chk({tag, ".out_data"},  out_data,          e_od);
        chk({tag, ".busy"},      {7'd0, busy},      {7'd0, e_busy});
    endtask

    // Inputs are set on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 4'b0000;
        in_valid_b = 4'b0000;
        out_ready  = 1'b1;
        data0 = 8'hA5; data1 = 8'h11; data2 = 8'h22; data3 = 8'h33;
        step();
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Single requester, burst end, pointer advance, early drop.
        vecs[0] = '{4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        vecs[3] = '{4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        vecs[4] = '{4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        vecs[5] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b1, 8'hA5, 1'b0};
        vecs[6] = '{4'b1001, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA5, 1'b0};
        vecs[7] = '{4'b1001, 1'b1, 2'd3, 4'b1000, 1'b0, 8'hA5, 1'b1};
        vecs[8] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 8'h33, 1'b1};
        vecs[9] = '{4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 8'h33, 1'b0};

        do_reset();
        chk_main("reset", 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            #1;
            chk_main($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rdy, vecs[i].ov, vecs[i].od, vecs[i].busy);
            step();
        end

        // All four requesting: bursts of 4 in order 0,1,2,3,0 with one idle cycle between.
        do_reset();
        in_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            logic       e_busy;
            logic [1:0] e_sel;
            logic [3:0] e_rdy;
            #1;
            e_busy = (c % 5) != 0;
            e_sel  = 2'((c / 5) % 4);
            e_rdy  = e_busy ? (4'b0001 << e_sel) : 4'b0000;
            chk($sformatf("rr c%0d busy", c), {7'd0, busy}, {7'd0, e_busy});
            chk($sformatf("rr c%0d in_ready", c), {4'd0, in_ready}, {4'd0, e_rdy});
            if (e_busy) chk($sformatf("rr c%0d sel", c), {6'd0, sel}, {6'd0, e_sel});
            step();
        end

        // Channel 2 drops after two bytes while channel 3 waits.
        do_reset();
        in_valid = 4'b1100;
        #1; chk_main("drop c0", 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0); step();
        #1; chk_main("drop c1", 2'd2, 4'b0100, 1'b0, 8'h00, 1'b1); step();
        #1; chk_main("drop c2", 2'd2, 4'b0100, 1'b1, 8'h22, 1'b1); step();
        in_valid = 4'b1000;
        #1; chk_main("drop c3", 2'd2, 4'b0100, 1'b1, 8'h22, 1'b1); step();
        #1; chk_main("drop c4", 2'd2, 4'b0000, 1'b0, 8'h22, 1'b0); step();
        #1; chk_main("drop c5", 2'd3, 4'b1000, 1'b0, 8'h22, 1'b1); step();

        // Output stall for five cycles, then resume with no loss or duplication.
        do_reset();
        in_valid = 4'b0001;
        data0    = 8'h3C;
        #1; chk_main("stall c0", 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0); step();
        #1; chk_main("stall c1", 2'd0, 4'b0001, 1'b0, 8'h00, 1'b1); step();
        data0     = 8'h3D;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1; chk_main($sformatf("stall hold%0d", c), 2'd0, 4'b0000, 1'b1, 8'h3C, 1'b1); step();
        end
        out_ready = 1'b1;
        #1; chk_main("stall c7", 2'd0, 4'b0001, 1'b1, 8'h3C, 1'b1); step();
        data0 = 8'h3E;
        #1; chk_main("stall c8", 2'd0, 4'b0001, 1'b1, 8'h3D, 1'b1); step();
        data0 = 8'h3F;
        #1; chk_main("stall c9", 2'd0, 4'b0001, 1'b1, 8'h3E, 1'b1); step();
        data0    = 8'h40;
        in_valid = 4'b0000;
        #1; chk_main("stall c10", 2'd0, 4'b0000, 1'b1, 8'h3F, 1'b0); step();
        #1; chk_main("stall c11", 2'd0, 4'b0000, 1'b0, 8'h3F, 1'b0); step();

        // Reset in the middle of a channel-2 burst.
        do_reset();
        in_valid = 4'b0100;
        step(); step(); step();
        #1; chk_main("midrst pre", 2'd2, 4'b0100, 1'b1, 8'h22, 1'b1);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 4'b0010;
        #1; chk_main("midrst c0", 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0); step();
        #1; chk_main("midrst c1", 2'd1, 4'b0010, 1'b0, 8'h00, 1'b1); step();
        #1; chk_main("midrst c2", 2'd1, 4'b0010, 1'b1, 8'h11, 1'b1); step();

        // MAX_BURST=1 instance: per-byte alternation between channels 1 and 3.
        do_reset();
        in_valid_b = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            logic       e_busy;
            logic [1:0] e_sel;
            #1;
            e_busy = (c % 2) == 1;
            e_sel  = ((c / 2) % 2 == 0) ? 2'd1 : 2'd3;
            chk($sformatf("b1 c%0d busy", c), {7'd0, busy_b}, {7'd0, e_busy});
            chk($sformatf("b1 c%0d in_ready", c), {4'd0, in_ready_b},
                {4'd0, e_busy ? (4'b0001 << e_sel) : 4'b0000});
            if (e_busy) chk($sformatf("b1 c%0d sel", c), {6'd0, sel_b}, {6'd0, e_sel});
            if (c >= 2) begin
                chk($sformatf("b1 c%0d out_valid", c), {7'd0, out_valid_b}, {7'd0, !e_busy});
                if (!e_busy)
                    chk($sformatf("b1 c%0d out_data", c), out_data_b,
                        ((c / 2) % 2 == 1) ? 8'h11 : 8'h13);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
